// File: rtl/wb_regfile.sv
// wb_regfile: write-back result select, 32x32 register file with two
// write-through bypass read ports, and a retired-instruction counter.
// Optional feature macro: WB_TRACE_EN adds registered commit trace outputs.
module wb_regfile #(
  parameter int XLEN      = 32,
  parameter int NREGS     = 32,
  parameter int INSTRET_W = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 W_valid,
  input  logic [1:0]           W_sel_result,
  input  logic                 W_we_rf,
  input  logic [XLEN-1:0]      W_dm_rd,
  input  logic [XLEN-1:0]      W_alu_o,
  input  logic [4:0]           W_rf_a3,
  input  logic [XLEN-1:0]      W_PC_P4,
  input  logic [XLEN-1:0]      W_ext,
  input  logic [4:0]           D_rf_a1,
  input  logic [4:0]           D_rf_a2,
  output logic [XLEN-1:0]      D_rf_rd1,
  output logic [XLEN-1:0]      D_rf_rd2,
  output logic [XLEN-1:0]      W_result,
  output logic [INSTRET_W-1:0] instret
`ifdef WB_TRACE_EN
  ,
  output logic                 trace_valid,
  output logic [4:0]           trace_rd,
  output logic [XLEN-1:0]      trace_data
`endif
);

  logic [XLEN-1:0]      r_rf [NREGS];
  logic [INSTRET_W-1:0] r_instret;
  logic                 w_commit;

  // Result mux: every encoding is covered, so no latch can form.
  always_comb begin
    W_result = W_alu_o;
    case (W_sel_result)
      2'b00:   W_result = W_alu_o;
      2'b01:   W_result = W_dm_rd;
      2'b10:   W_result = W_PC_P4;
      default: W_result = W_ext;
    endcase
  end

  // A write lands only for a real instruction targeting a non-zero register.
  assign w_commit = W_valid && W_we_rf && (W_rf_a3 != 5'd0);

  // Register array update; x0 is never written so it stays zero forever.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) begin
        r_rf[i] <= '0;
      end
    end else if (w_commit) begin
      r_rf[W_rf_a3] <= W_result;
    end
  end

  // Retire counter: every valid instruction counts, writing or not; wraps silently.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_instret <= '0;
    end else if (W_valid) begin
      r_instret <= r_instret + INSTRET_W'(1);
    end
  end

  assign instret = r_instret;

  // Read port 1: x0 forced to zero, then same-cycle bypass of the commit.
  always_comb begin
    D_rf_rd1 = r_rf[D_rf_a1];
    if (w_commit && (D_rf_a1 == W_rf_a3)) D_rf_rd1 = W_result;
    if (D_rf_a1 == 5'd0) D_rf_rd1 = '0;
  end

  // Read port 2: identical policy to port 1.
  always_comb begin
    D_rf_rd2 = r_rf[D_rf_a2];
    if (w_commit && (D_rf_a2 == W_rf_a3)) D_rf_rd2 = W_result;
    if (D_rf_a2 == 5'd0) D_rf_rd2 = '0;
  end

`ifdef WB_TRACE_EN
  // Trace mirrors each commit one cycle later; dropped x0 writes never appear.
  always_ff @(posedge clk) begin
    if (!rst) begin
      trace_valid <= 1'b0;
      trace_rd    <= '0;
      trace_data  <= '0;
    end else begin
      trace_valid <= w_commit;
      if (w_commit) begin
        trace_rd   <= W_rf_a3;
        trace_data <= W_result;
      end
    end
  end
`endif

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile.
// Inputs are driven at the falling edge and outputs sampled 1 time unit later.
// Expected values are hand-computed constants plus a tracked instret model.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        W_valid;
  logic [1:0]  W_sel_result;
  logic        W_we_rf;
  logic [31:0] W_dm_rd, W_alu_o, W_PC_P4, W_ext;
  logic [4:0]  W_rf_a3, D_rf_a1, D_rf_a2;
  logic [31:0] D_rf_rd1, D_rf_rd2, W_result;
  logic [63:0] instret;

  int tests  = 0;
  int failed = 0;
  logic [63:0] exp_instret;

  wb_regfile dut (
    .clk          (clk),
    .rst          (rst),
    .W_valid      (W_valid),
    .W_sel_result (W_sel_result),
    .W_we_rf      (W_we_rf),
    .W_dm_rd      (W_dm_rd),
    .W_alu_o      (W_alu_o),
    .W_rf_a3      (W_rf_a3),
    .W_PC_P4      (W_PC_P4),
    .W_ext        (W_ext),
    .D_rf_a1      (D_rf_a1),
    .D_rf_a2      (D_rf_a2),
    .D_rf_rd1     (D_rf_rd1),
    .D_rf_rd2     (D_rf_rd2),
    .W_result     (W_result),
    .instret      (instret)
  );

  always #5 clk = ~clk;

  task automatic drive_w(input logic v, input logic we, input logic [1:0] sel,
                         input logic [4:0] a3, input logic [31:0] alu);
    W_valid      = v;
    W_we_rf      = we;
    W_sel_result = sel;
    W_rf_a3      = a3;
    W_alu_o      = alu;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive_w(1'b1, 1'b1, 2'b00, 5'd5, 32'h0000_0077);
    W_dm_rd = 32'h0; W_PC_P4 = 32'h0; W_ext = 32'h0;
    D_rf_a1 = 5'd5; D_rf_a2 = 5'd31;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    drive_w(1'b0, 1'b0, 2'b00, 5'd0, 32'h0000_0077);
    #1;
    tests++;
    if (D_rf_rd1 !== 32'h0) begin failed++; $display("FAIL reset_rd1 got %h want %h", D_rf_rd1, 32'h0); end
    tests++;
    if (D_rf_rd2 !== 32'h0) begin failed++; $display("FAIL reset_rd2 got %h want %h", D_rf_rd2, 32'h0); end
    tests++;
    if (instret !== 64'h0) begin failed++; $display("FAIL reset_instret got %h want %h", instret, 64'h0); end
    tests++;
    if (W_result !== 32'h77) begin failed++; $display("FAIL reset_wresult got %h want %h", W_result, 32'h77); end
    exp_instret = 64'h0;
  endtask

  task automatic test_result_select();
    logic [31:0] exp_v [4];
    exp_v[0] = 32'h11; exp_v[1] = 32'h22; exp_v[2] = 32'h33; exp_v[3] = 32'h44;
    W_dm_rd = 32'h22; W_PC_P4 = 32'h33; W_ext = 32'h44;
    D_rf_a1 = 5'd1; D_rf_a2 = 5'd2;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive_w(1'b1, 1'b1, 2'(i), 5'd3, 32'h11);
      #1;
      tests++;
      if (W_result !== exp_v[i]) begin failed++; $display("FAIL sel%0d_wresult got %h want %h", i, W_result, exp_v[i]); end
      @(posedge clk);
      exp_instret++;
      #1;
      tests++;
      if (dut.r_rf[3] !== exp_v[i]) begin failed++; $display("FAIL sel%0d_x3 got %h want %h", i, dut.r_rf[3], exp_v[i]); end
    end
    @(negedge clk);
    drive_w(1'b0, 1'b0, 2'b00, 5'd0, 32'h0);
    D_rf_a1 = 5'd3;
    #1;
    tests++;
    if (D_rf_rd1 !== 32'h44) begin failed++; $display("FAIL sel_x3_port got %h want %h", D_rf_rd1, 32'h44); end
    tests++;
    if (instret !== 64'd4) begin failed++; $display("FAIL sel_instret got %h want %h", instret, 64'd4); end
  endtask

  task automatic test_bypass_x0();
    @(negedge clk);
    drive_w(1'b1, 1'b1, 2'b00, 5'd7, 32'hDEAD_BEEF);
    D_rf_a1 = 5'd7; D_rf_a2 = 5'd7;
    #1;
    tests++;
    if (D_rf_rd1 !== 32'hDEAD_BEEF) begin failed++; $display("FAIL bypass_rd1 got %h want %h", D_rf_rd1, 32'hDEAD_BEEF); end
    tests++;
    if (D_rf_rd2 !== 32'hDEAD_BEEF) begin failed++; $display("FAIL bypass_rd2 got %h want %h", D_rf_rd2, 32'hDEAD_BEEF); end
    @(posedge clk);
    exp_instret++;
    @(negedge clk);
    drive_w(1'b1, 1'b1, 2'b00, 5'd0, 32'h5);
    D_rf_a1 = 5'd0; D_rf_a2 = 5'd7;
    #1;
    tests++;
    if (D_rf_rd1 !== 32'h0) begin failed++; $display("FAIL x0_bypass got %h want %h", D_rf_rd1, 32'h0); end
    tests++;
    if (D_rf_rd2 !== 32'hDEAD_BEEF) begin failed++; $display("FAIL x7_stored got %h want %h", D_rf_rd2, 32'hDEAD_BEEF); end
    @(posedge clk);
    exp_instret++;
    @(negedge clk);
    drive_w(1'b0, 1'b0, 2'b00, 5'd0, 32'h0);
    #1;
    tests++;
    if (D_rf_rd1 !== 32'h0) begin failed++; $display("FAIL x0_after got %h want %h", D_rf_rd1, 32'h0); end
    tests++;
    if (instret !== exp_instret) begin failed++; $display("FAIL bypass_instret got %h want %h", instret, exp_instret); end
  endtask

  task automatic test_bubble();
    @(negedge clk);
    drive_w(1'b0, 1'b1, 2'b00, 5'd9, 32'h99);
    D_rf_a1 = 5'd9;
    #1;
    tests++;
    if (D_rf_rd1 !== 32'h0) begin failed++; $display("FAIL bubble_nobypass got %h want %h", D_rf_rd1, 32'h0); end
    @(posedge clk);
    @(negedge clk);
    drive_w(1'b0, 1'b0, 2'b00, 5'd0, 32'h0);
    #1;
    tests++;
    if (D_rf_rd1 !== 32'h0) begin failed++; $display("FAIL bubble_x9 got %h want %h", D_rf_rd1, 32'h0); end
    tests++;
    if (instret !== exp_instret) begin failed++; $display("FAIL bubble_instret got %h want %h", instret, exp_instret); end
  endtask

  task automatic test_retire_wrap();
    @(negedge clk);
    drive_w(1'b1, 1'b0, 2'b00, 5'd3, 32'h5555);
    D_rf_a1 = 5'd3;
    @(posedge clk);
    exp_instret++;
    @(negedge clk);
    drive_w(1'b0, 1'b0, 2'b00, 5'd0, 32'h0);
    #1;
    tests++;
    if (instret !== exp_instret) begin failed++; $display("FAIL noweretire_instret got %h want %h", instret, exp_instret); end
    tests++;
    if (D_rf_rd1 !== 32'h44) begin failed++; $display("FAIL noweretire_x3 got %h want %h", D_rf_rd1, 32'h44); end
    force dut.r_instret = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.r_instret;
    #1;
    tests++;
    if (instret !== 64'hFFFF_FFFF_FFFF_FFFF) begin failed++; $display("FAIL wrap_preload got %h want all-ones", instret); end
    W_valid = 1'b1;
    @(posedge clk);
    #1;
    W_valid = 1'b0;
    tests++;
    if (instret !== 64'h0) begin failed++; $display("FAIL wrap_instret got %h want %h", instret, 64'h0); end
    exp_instret = 64'h0;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    drive_w(1'b1, 1'b1, 2'b00, 5'd4, 32'h1234);
    @(posedge clk);
    exp_instret++;
    @(negedge clk);
    drive_w(1'b0, 1'b0, 2'b00, 5'd0, 32'h0);
    D_rf_a1 = 5'd4; D_rf_a2 = 5'd3;
    #1;
    tests++;
    if (D_rf_rd1 !== 32'h1234) begin failed++; $display("FAIL mid_x4_pre got %h want %h", D_rf_rd1, 32'h1234); end
    tests++;
    if (instret !== exp_instret) begin failed++; $display("FAIL mid_instret_pre got %h want %h", instret, exp_instret); end
    @(negedge clk);
    rst = 1'b0;
    drive_w(1'b1, 1'b1, 2'b00, 5'd4, 32'hAAAA);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    drive_w(1'b0, 1'b0, 2'b00, 5'd0, 32'h0);
    #1;
    tests++;
    if (D_rf_rd1 !== 32'h0) begin failed++; $display("FAIL mid_x4_post got %h want %h", D_rf_rd1, 32'h0); end
    tests++;
    if (D_rf_rd2 !== 32'h0) begin failed++; $display("FAIL mid_x3_post got %h want %h", D_rf_rd2, 32'h0); end
    tests++;
    if (instret !== 64'h0) begin failed++; $display("FAIL mid_instret_post got %h want %h", instret, 64'h0); end
  endtask

  initial begin
    test_reset();
    test_result_select();
    test_bypass_x0();
    test_bubble();
    test_retire_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
